dp_ram_be: RTL and testbench
============================

Name: dp_ram_be

Overview:
- Parametrised true dual-port synchronous RAM; successor to the plain two-port array used by the EDC datapath.
- Adds per-lane byte enables, port enables with read-valid strobes, selectable read latency and same-port read-during-write mode.
- Adds deterministic cross-port collision handling with a collision flag, and a post-reset clear engine so that no datapath stage sees uninitialised words.

Parameters:
- P_DATA_W, 640, word width in bits; must be a multiple of P_LANE_W.
- P_LANE_W, 8, bits per write-enable lane. Derived: L = P_DATA_W/P_LANE_W lanes.
- P_LOG2_RAM_DEPTH, 9, address width; depth D = 2**P_LOG2_RAM_DEPTH.
- P_RD_LAT, 1, read latency in cycles; legal values 1 or 2.
- P_RDW_MODE, 0, same-port read-during-write: 0 = write-first, 1 = read-first.
- P_INIT_VAL, 0, P_DATA_W-bit value written to every word by the clear engine.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_a_en  in  1  port A access enable.
- i_a_wr  in  1  port A write; only meaningful when i_a_en=1.
- i_a_be  in  L  port A lane write enables.
- i_a_addr  in  P_LOG2_RAM_DEPTH  port A address.
- i_a_data  in  P_DATA_W  port A write data.
- o_a_data  out  P_DATA_W  port A read data.
- o_a_vld  out  1  o_a_data valid strobe.
- i_b_en, i_b_wr, i_b_be, i_b_addr, i_b_data, o_b_data, o_b_vld: same as port A, for port B.
- o_ready  out  1  clear engine finished; accesses are accepted.
- o_collision  out  1  one-cycle pulse: cross-port address clash.

Behaviour:
- Reset (async assert, sync release):
  - o_a_data, o_b_data = 0; o_a_vld, o_b_vld, o_ready, o_collision = 0.
  - All pipeline registers = 0; clear engine enters CLEAR with counter = 0.
  - Array contents are not reset directly.
- FSM:
  - CLEAR: write P_INIT_VAL to word[counter] each cycle; counter += 1. After writing word D-1, go to RUN.
  - RUN: o_ready=1 from the first RUN cycle; terminal state until reset.
  - The clear takes exactly D cycles after reset release.
  - Reset mid-clear restarts at counter 0.
- While o_ready=0, all port inputs are ignored: no writes, vld stays 0.
- Accepted access (RUN, i_x_en=1):
  - Write: lanes with i_x_be[k]=1 are updated with i_x_data lane k. Other lanes keep their old contents.
  - Write with i_x_be all-zero: no array change, but still returns data and vld.
  - Every accepted access, read or write, returns a word on o_x_data with o_x_vld=1 exactly P_RD_LAT cycles after the accepting edge.
  - P_RD_LAT=2 adds one output register stage; throughput is one access per port per cycle for both latencies.
- o_x_data holds its last value when vld=0; it is not zeroed.
- Same-port write, P_RDW_MODE=0: returned word is the merged new word (new enabled lanes, old other lanes).
- Same-port write, P_RDW_MODE=1: returned word is the pre-write contents.
- Cross-port, same cycle, equal addresses, both enabled, at least one writing:
  - A port that is only reading returns the pre-write contents, regardless of P_RDW_MODE.
  - Both writing: per lane, A wins where i_a_be[k]=1, B applies where only i_b_be[k]=1.
  - o_collision=1 on the cycle after the clash, for one cycle per clashing cycle.
  - Both ports reading the same address is not a collision.
- Addresses wrap naturally; there is no out-of-range condition.

Test Plan:
- Release reset, then hold i_a_en=1 with a read of addr 5 throughout -> o_ready rises exactly 512 cycles after release; no o_a_vld before then; the first read after ready returns P_INIT_VAL=0.
- P_RD_LAT=1: write A addr 3 = 0xAA..AA with all lanes enabled; next cycle read B addr 3 -> o_b_vld one cycle later with 0xAA..AA. Repeat with P_RD_LAT=2 -> vld and data arrive two cycles after the read.
- Byte enable: addr 7 holds 0x11 in every lane; write A 0xFF.. with be=...0101 -> readback has 0xFF in lanes 0 and 2 and 0x11 elsewhere.
- Read-during-write on addr 9 (old 0x00, new 0x5A with be all-ones) -> mode 0 returns 0x5A, mode 1 returns 0x00, each with vld set.
- A and B write addr 12 in the same cycle, A be=lower half 0x33, B be=all-ones 0x44 -> word = upper half 0x44, lower half 0x33; o_collision pulses for one cycle. Repeat with A reading addr 12 while B writes -> A returns the old word and o_collision pulses.
- Assert i_rst_n low when the clear counter reaches 200 -> all outputs go to 0 immediately; after release, o_ready rises after a full 512 cycles.

Source files
------------

// File: rtl/dp_ram_be.sv
// True dual-port synchronous RAM with lane write enables, read-valid strobes,
// selectable read latency, deterministic cross-port collisions and a post-reset clear engine.
module dp_ram_be #(
    parameter int unsigned          P_DATA_W         = 640,
    parameter int unsigned          P_LANE_W         = 8,
    parameter int unsigned          P_LOG2_RAM_DEPTH = 9,
    parameter int unsigned          P_RD_LAT         = 1,
    parameter int unsigned          P_RDW_MODE       = 0,
    parameter logic [P_DATA_W-1:0]  P_INIT_VAL       = '0
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_a_en,
    input  logic                               i_a_wr,
    input  logic [P_DATA_W/P_LANE_W-1:0]       i_a_be,
    input  logic [P_LOG2_RAM_DEPTH-1:0]        i_a_addr,
    input  logic [P_DATA_W-1:0]                i_a_data,
    output logic [P_DATA_W-1:0]                o_a_data,
    output logic                               o_a_vld,
    input  logic                               i_b_en,
    input  logic                               i_b_wr,
    input  logic [P_DATA_W/P_LANE_W-1:0]       i_b_be,
    input  logic [P_LOG2_RAM_DEPTH-1:0]        i_b_addr,
    input  logic [P_DATA_W-1:0]                i_b_data,
    output logic [P_DATA_W-1:0]                o_b_data,
    output logic                               o_b_vld,
    output logic                               o_ready,
    output logic                               o_collision
);

    localparam int unsigned    L         = P_DATA_W / P_LANE_W;
    localparam int unsigned    D         = 2 ** P_LOG2_RAM_DEPTH;
    localparam int unsigned    AW        = P_LOG2_RAM_DEPTH;
    localparam logic [AW-1:0]  LAST_ADDR = AW'(D - 1);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         cnt_q, cnt_d;
    logic                  ready_q;
    logic                  clr_we_c;

    logic [P_DATA_W-1:0]   mem_q [D];

    logic                  a_acc_c, b_acc_c, a_we_c, b_we_c, addr_eq_c, clash_c;
    logic [P_DATA_W-1:0]   a_old_c, b_old_c, a_new_c, b_new_c, a_ret_c, b_ret_c;

    logic                  a_vld1_q, b_vld1_q, coll_q;
    logic [P_DATA_W-1:0]   a_dat1_q, b_dat1_q;

    // Overlay the enabled lanes of wdat onto base.
    function automatic logic [P_DATA_W-1:0] lane_merge(input logic [P_DATA_W-1:0] base,
                                                       input logic [P_DATA_W-1:0] wdat,
                                                       input logic [L-1:0]        be);
        logic [P_DATA_W-1:0] r;
        r = base;
        for (int unsigned k = 0; k < L; k++) begin
            if (be[k]) r[k*P_LANE_W +: P_LANE_W] = wdat[k*P_LANE_W +: P_LANE_W];
        end
        return r;
    endfunction

    // Clear engine state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == ST_RUN);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_we_c = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we_c = 1'b1;
                cnt_d    = cnt_q + AW'(1);
                if (cnt_q == LAST_ADDR) state_d = ST_RUN;
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    assign a_acc_c   = ready_q & i_a_en;
    assign b_acc_c   = ready_q & i_b_en;
    assign a_we_c    = a_acc_c & i_a_wr;
    assign b_we_c    = b_acc_c & i_b_wr;
    assign addr_eq_c = (i_a_addr == i_b_addr);
    assign clash_c   = a_acc_c & b_acc_c & addr_eq_c & (a_we_c | b_we_c);

    // Storage; B is applied before A so A owns every lane both ports enable.
    always_ff @(posedge i_clk) begin
        if (clr_we_c) mem_q[cnt_q] <= P_INIT_VAL;
        if (b_we_c) begin
            for (int unsigned k = 0; k < L; k++) begin
                if (i_b_be[k]) mem_q[i_b_addr][k*P_LANE_W +: P_LANE_W] <= i_b_data[k*P_LANE_W +: P_LANE_W];
            end
        end
        if (a_we_c) begin
            for (int unsigned k = 0; k < L; k++) begin
                if (i_a_be[k]) mem_q[i_a_addr][k*P_LANE_W +: P_LANE_W] <= i_a_data[k*P_LANE_W +: P_LANE_W];
            end
        end
    end

    // Words each port returns: pre-write contents or the final merged word after this edge.
    always_comb begin
        a_old_c = mem_q[i_a_addr];
        b_old_c = mem_q[i_b_addr];
        a_new_c = a_old_c;
        b_new_c = b_old_c;
        if (b_we_c && addr_eq_c) a_new_c = lane_merge(a_new_c, i_b_data, i_b_be);
        if (a_we_c)              a_new_c = lane_merge(a_new_c, i_a_data, i_a_be);
        if (b_we_c)              b_new_c = lane_merge(b_new_c, i_b_data, i_b_be);
        if (a_we_c && addr_eq_c) b_new_c = lane_merge(b_new_c, i_a_data, i_a_be);
        a_ret_c = (a_we_c && (P_RDW_MODE == 32'd0)) ? a_new_c : a_old_c;
        b_ret_c = (b_we_c && (P_RDW_MODE == 32'd0)) ? b_new_c : b_old_c;
    end

    // First output stage; data holds while no access is returned.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_vld1_q <= 1'b0;
            b_vld1_q <= 1'b0;
            a_dat1_q <= '0;
            b_dat1_q <= '0;
            coll_q   <= 1'b0;
        end else begin
            a_vld1_q <= a_acc_c;
            b_vld1_q <= b_acc_c;
            coll_q   <= clash_c;
            if (a_acc_c) a_dat1_q <= a_ret_c;
            if (b_acc_c) b_dat1_q <= b_ret_c;
        end
    end

    generate
        if (P_RD_LAT >= 2) begin : g_lat2
            logic                a_vld2_q, b_vld2_q;
            logic [P_DATA_W-1:0] a_dat2_q, b_dat2_q;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    a_vld2_q <= 1'b0;
                    b_vld2_q <= 1'b0;
                    a_dat2_q <= '0;
                    b_dat2_q <= '0;
                end else begin
                    a_vld2_q <= a_vld1_q;
                    b_vld2_q <= b_vld1_q;
                    if (a_vld1_q) a_dat2_q <= a_dat1_q;
                    if (b_vld1_q) b_dat2_q <= b_dat1_q;
                end
            end

            assign o_a_data = a_dat2_q;
            assign o_a_vld  = a_vld2_q;
            assign o_b_data = b_dat2_q;
            assign o_b_vld  = b_vld2_q;
        end else begin : g_lat1
            assign o_a_data = a_dat1_q;
            assign o_a_vld  = a_vld1_q;
            assign o_b_data = b_dat1_q;
            assign o_b_vld  = b_vld1_q;
        end
    endgenerate

    assign o_ready     = ready_q;
    assign o_collision = coll_q;

endmodule

// File: tb/tb_dp_ram_be.sv
// Bench for dp_ram_be: two instances (latency 1/write-first, latency 2/read-first)
// driven in lockstep and checked every cycle against an array-based model.
module tb_dp_ram_be;

    localparam int unsigned DW    = 640;
    localparam int unsigned LW    = 8;
    localparam int unsigned L     = DW / LW;
    localparam int unsigned AW    = 9;
    localparam int unsigned DEPTH = 512;
    localparam logic [DW-1:0] INIT = '0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          a_en, a_wr, b_en, b_wr;
    logic [L-1:0]  a_be, b_be;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_data, b_data;

    logic [DW-1:0] o_a_data0, o_b_data0, o_a_data1, o_b_data1;
    logic          o_a_vld0, o_b_vld0, o_a_vld1, o_b_vld1;
    logic          o_ready0, o_ready1, o_coll0, o_coll1;

    int n_vec = 0;
    int n_err = 0;

    dp_ram_be #(.P_DATA_W(DW), .P_LANE_W(LW), .P_LOG2_RAM_DEPTH(AW),
                .P_RD_LAT(1), .P_RDW_MODE(0), .P_INIT_VAL(INIT)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_a_en(a_en), .i_a_wr(a_wr), .i_a_be(a_be), .i_a_addr(a_addr), .i_a_data(a_data),
        .o_a_data(o_a_data0), .o_a_vld(o_a_vld0),
        .i_b_en(b_en), .i_b_wr(b_wr), .i_b_be(b_be), .i_b_addr(b_addr), .i_b_data(b_data),
        .o_b_data(o_b_data0), .o_b_vld(o_b_vld0),
        .o_ready(o_ready0), .o_collision(o_coll0));

    dp_ram_be #(.P_DATA_W(DW), .P_LANE_W(LW), .P_LOG2_RAM_DEPTH(AW),
                .P_RD_LAT(2), .P_RDW_MODE(1), .P_INIT_VAL(INIT)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_a_en(a_en), .i_a_wr(a_wr), .i_a_be(a_be), .i_a_addr(a_addr), .i_a_data(a_data),
        .o_a_data(o_a_data1), .o_a_vld(o_a_vld1),
        .i_b_en(b_en), .i_b_wr(b_wr), .i_b_be(b_be), .i_b_addr(b_addr), .i_b_data(b_data),
        .o_b_data(o_b_data1), .o_b_vld(o_b_vld1),
        .o_ready(o_ready1), .o_collision(o_coll1));

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: instance i has latency i+1 and read-during-write mode i.
    logic [DW-1:0] mem_m [DEPTH];
    int            clr_cnt;
    logic          ready_m, exp_coll;
    logic          hva [2][2];
    logic          hvb [2][2];
    logic [DW-1:0] hda [2][2];
    logic [DW-1:0] hdb [2][2];
    logic [DW-1:0] helda [2];
    logic [DW-1:0] heldb [2];
    logic          exp_va [2];
    logic          exp_vb [2];
    logic          m_aacc, m_bacc, m_aw, m_bw;
    logic [DW-1:0] old_a, old_b, fin_a, fin_b, ret_a, ret_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt  = 0;
            ready_m  = 1'b0;
            exp_coll = 1'b0;
            for (int i = 0; i < 2; i++) begin
                for (int s = 0; s < 2; s++) begin
                    hva[i][s] = 1'b0; hvb[i][s] = 1'b0;
                    hda[i][s] = '0;   hdb[i][s] = '0;
                end
                helda[i] = '0; heldb[i] = '0;
                exp_va[i] = 1'b0; exp_vb[i] = 1'b0;
            end
        end else begin
            m_aacc = ready_m && a_en;
            m_bacc = ready_m && b_en;
            m_aw   = m_aacc && a_wr;
            m_bw   = m_bacc && b_wr;
            old_a  = mem_m[a_addr];
            old_b  = mem_m[b_addr];
            if (m_bw) for (int k = 0; k < int'(L); k++)
                if (b_be[k]) mem_m[b_addr][k*LW +: LW] = b_data[k*LW +: LW];
            if (m_aw) for (int k = 0; k < int'(L); k++)
                if (a_be[k]) mem_m[a_addr][k*LW +: LW] = a_data[k*LW +: LW];
            fin_a    = mem_m[a_addr];
            fin_b    = mem_m[b_addr];
            exp_coll = m_aacc && m_bacc && (a_addr == b_addr) && (m_aw || m_bw);
            for (int i = 0; i < 2; i++) begin
                ret_a = (m_aw && i == 0) ? fin_a : old_a;
                ret_b = (m_bw && i == 0) ? fin_b : old_b;
                hva[i][1] = hva[i][0]; hva[i][0] = m_aacc;
                hda[i][1] = hda[i][0]; hda[i][0] = ret_a;
                hvb[i][1] = hvb[i][0]; hvb[i][0] = m_bacc;
                hdb[i][1] = hdb[i][0]; hdb[i][0] = ret_b;
                if (hva[i][i]) helda[i] = hda[i][i];
                if (hvb[i][i]) heldb[i] = hdb[i][i];
                exp_va[i] = hva[i][i];
                exp_vb[i] = hvb[i][i];
            end
            if (!ready_m) begin
                clr_cnt++;
                if (clr_cnt == int'(DEPTH)) begin
                    ready_m = 1'b1;
                    for (int w = 0; w < int'(DEPTH); w++) mem_m[w] = INIT;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        chk("ready0", DW'(o_ready0), DW'(ready_m));
        chk("ready1", DW'(o_ready1), DW'(ready_m));
        chk("coll0", DW'(o_coll0), DW'(exp_coll));
        chk("coll1", DW'(o_coll1), DW'(exp_coll));
        chk("a_vld0", DW'(o_a_vld0), DW'(exp_va[0]));
        chk("a_vld1", DW'(o_a_vld1), DW'(exp_va[1]));
        chk("b_vld0", DW'(o_b_vld0), DW'(exp_vb[0]));
        chk("b_vld1", DW'(o_b_vld1), DW'(exp_vb[1]));
        chk("a_data0", o_a_data0, helda[0]);
        chk("a_data1", o_a_data1, helda[1]);
        chk("b_data0", o_b_data0, heldb[0]);
        chk("b_data1", o_b_data1, heldb[1]);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_en = 1'b0; a_wr = 1'b0; a_be = '0; a_addr = '0; a_data = '0;
        b_en = 1'b0; b_wr = 1'b0; b_be = '0; b_addr = '0; b_data = '0;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] r;
        for (int i = 0; i < int'(DW / 32); i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [L-1:0] rnd_be();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[L-1:0];
    endfunction

    // Hold a read of addr 5 on A and count edges until ready.
    task automatic wait_ready(input string nm);
        int rdy_at;
        logic early_vld;
        rdy_at = 0;
        early_vld = 1'b0;
        a_en = 1'b1; a_wr = 1'b0; a_addr = AW'(5);
        for (int i = 1; i <= 600; i++) begin
            step();
            if (o_ready0) begin
                rdy_at = i;
                break;
            end
            if (o_a_vld0 || o_a_vld1) early_vld = 1'b1;
        end
        chk({nm, "_ready_cycles"}, DW'(rdy_at), DW'(512));
        chk({nm, "_early_vld"}, DW'(early_vld), DW'(0));
    endtask

    logic [DW-1:0] exp_w;

    initial begin
        rst_n = 1'b1;
        idle();
        #1 rst_n = 1'b0;
        repeat (3) step();
        chk("rst_ready", DW'(o_ready0), DW'(0));
        chk("rst_a_data1", o_a_data1, DW'(0));
        #2 rst_n = 1'b1;

        wait_ready("init");
        step();
        chk("first_rd_vld0", DW'(o_a_vld0), DW'(1));
        chk("first_rd_data0", o_a_data0, INIT);
        step();
        chk("first_rd_vld1", DW'(o_a_vld1), DW'(1));
        chk("first_rd_data1", o_a_data1, INIT);

        // Write A then read B on addr 3.
        idle();
        a_en = 1'b1; a_wr = 1'b1; a_be = '1; a_addr = AW'(3); a_data = {L{8'hAA}};
        step();
        idle();
        b_en = 1'b1; b_addr = AW'(3);
        step();
        idle();
        chk("lat1_b_vld", DW'(o_b_vld0), DW'(1));
        chk("lat1_b_data", o_b_data0, {L{8'hAA}});
        chk("lat2_b_vld_early", DW'(o_b_vld1), DW'(0));
        step();
        chk("lat2_b_vld", DW'(o_b_vld1), DW'(1));
        chk("lat2_b_data", o_b_data1, {L{8'hAA}});

        // Byte enables on addr 7.
        a_en = 1'b1; a_wr = 1'b1; a_be = '1; a_addr = AW'(7); a_data = {L{8'h11}};
        step();
        a_be = L'(5); a_data = {L{8'hFF}};
        step();
        idle();
        b_en = 1'b1; b_addr = AW'(7);
        step();
        idle();
        exp_w = {L{8'h11}};
        exp_w[7:0] = 8'hFF;
        exp_w[23:16] = 8'hFF;
        chk("be_readback", o_b_data0, exp_w);

        // Read-during-write on addr 9.
        a_en = 1'b1; a_wr = 1'b1; a_be = '1; a_addr = AW'(9); a_data = {L{8'h5A}};
        step();
        idle();
        chk("rdw_wf_vld", DW'(o_a_vld0), DW'(1));
        chk("rdw_wf_data", o_a_data0, {L{8'h5A}});
        step();
        chk("rdw_rf_vld", DW'(o_a_vld1), DW'(1));
        chk("rdw_rf_data", o_a_data1, DW'(0));

        // Double write collision on addr 12.
        a_en = 1'b1; a_wr = 1'b1; a_addr = AW'(12); a_data = {L{8'h33}};
        a_be = {{(L/2){1'b0}}, {(L/2){1'b1}}};
        b_en = 1'b1; b_wr = 1'b1; b_addr = AW'(12); b_data = {L{8'h44}}; b_be = '1;
        step();
        idle();
        chk("coll_ww0", DW'(o_coll0), DW'(1));
        chk("coll_ww1", DW'(o_coll1), DW'(1));
        step();
        chk("coll_pulse_end", DW'(o_coll0), DW'(0));
        a_en = 1'b1; a_addr = AW'(12);
        step();
        exp_w = {{(L/2){8'h44}}, {(L/2){8'h33}}};
        chk("coll_ww_word", o_a_data0, exp_w);
        // A reads while B writes the same address.
        b_en = 1'b1; b_wr = 1'b1; b_addr = AW'(12); b_data = {L{8'h55}}; b_be = '1;
        step();
        idle();
        chk("coll_rw", DW'(o_coll0), DW'(1));
        chk("coll_rw_old0", o_a_data0, exp_w);
        step();
        chk("coll_rw_old1", o_a_data1, exp_w);

        // Random traffic over a small address window to provoke collisions.
        for (int c = 0; c < 1500; c++) begin
            a_en = 1'($urandom_range(0, 3) != 0); a_wr = 1'($urandom);
            a_be = ($urandom_range(0, 7) == 0) ? '0 : rnd_be();
            a_addr = AW'($urandom_range(0, 15)); a_data = rnd_data();
            b_en = 1'($urandom_range(0, 3) != 0); b_wr = 1'($urandom);
            b_be = ($urandom_range(0, 7) == 0) ? '1 : rnd_be();
            b_addr = AW'($urandom_range(0, 15)); b_data = rnd_data();
            step();
        end
        idle();
        step();

        // Reset while running: outputs clear at once.
        #2 rst_n = 1'b0;
        #1;
        chk("arst_a_data0", o_a_data0, DW'(0));
        chk("arst_b_data1", o_b_data1, DW'(0));
        chk("arst_ready", DW'(o_ready0), DW'(0));
        chk("arst_vld", DW'({o_a_vld0, o_b_vld0, o_a_vld1, o_b_vld1, o_coll0}), DW'(0));
        step();
        #2 rst_n = 1'b1;

        // Reset again when the clear counter reaches 200.
        a_en = 1'b1; a_addr = AW'(5);
        repeat (200) step();
        #2 rst_n = 1'b0;
        #1;
        chk("midclr_ready", DW'(o_ready0), DW'(0));
        chk("midclr_vld", DW'({o_a_vld0, o_a_vld1}), DW'(0));
        step();
        #2 rst_n = 1'b1;
        wait_ready("reclear");
        step();
        chk("reclear_rd0", o_a_data0, INIT);
        idle();
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
